storage_arbiter: RTL

- Sequential arbiter sharing the single-port matrix storage between three requesters: input subsystem (read/write), display subsystem (read-only) and calculator core (read/write).
- Replaces static mode-based muxing with a req/gnt handshake, round-robin fairness and bounded bursts.
- Drives registered address, data and write-enable to storage.
- Returns the storage read data to the owning requester with a per-requester valid strobe.

---
 rtl/storage_arbiter_pkg.sv | 36 +++
 rtl/storage_arbiter_rr_pick3.sv | 36 +++
 rtl/storage_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/storage_arbiter_pkg.sv
// Shared definitions for the storage arbiter slice.
// Contents: requester index constants, requester count, FSM state encoding,
// and small helpers for index/one-hot conversion and round-robin stepping.
package storage_arbiter_pkg;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_IN   = 2'd0;
  localparam logic [1:0] REQ_DISP = 2'd1;
  localparam logic [1:0] REQ_CALC = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Requester that follows idx in the in -> disp -> calc -> in ring.
  function automatic logic [1:0] next_req(input logic [1:0] idx);
    case (idx)
      REQ_IN:   return REQ_DISP;
      REQ_DISP: return REQ_CALC;
      default:  return REQ_IN;
    endcase
  endfunction

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    if (oh[2]) return REQ_CALC;
    if (oh[1]) return REQ_DISP;
    return REQ_IN;
  endfunction

endpackage

// File: rtl/storage_arbiter_rr_pick3.sv
// Combinational round-robin selector for three requesters.
// Ports:
//   req    - request vector, bit index = requester index
//   ptr    - requester with highest priority this round
//   winner - one-hot winner (all zero when req is zero)
// Search order starts at ptr and wraps in -> disp -> calc -> in.
module storage_arbiter_rr_pick3
  import storage_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    winner = '0;
    case (ptr)
      REQ_DISP: begin
        if      (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
      end
      REQ_CALC: begin
        if      (req[2]) winner = 3'b100;
        else if (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
      end
      default: begin
        if      (req[0]) winner = 3'b001;
        else if (req[1]) winner = 3'b010;
        else if (req[2]) winner = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/storage_arbiter.sv
// Arbiter sharing a single-port storage between the input subsystem,
// the display subsystem (read-only) and the calculator core.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   i_req_*/o_gnt_*                  - per-requester request / grant
//   i_addr_*, i_wdata_*, i_we_*      - per-requester beat payload
//   o_rvalid_*                       - per-requester read-data strobe
//   o_storage_addr/data/we           - registered storage command
//   i_storage_rdata                  - storage read data (1 cycle latency)
//   o_rdata                          - read data shared by all requesters
//   dbg_state                        - current arbiter FSM state
//
// Handshake: a requester holds i_req_x high while it wants storage. Once
// o_gnt_x is high, every cycle with i_req_x & o_gnt_x is one accepted beat
// (its addr/wdata/we are sampled that cycle). Dropping i_req_x while granted
// releases the storage; dropping it before being granted is allowed and
// issues nothing. o_rvalid_x pulses two cycles after each accepted read
// beat, together with valid data on o_rdata.
module storage_arbiter
  import storage_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_in,
  input  logic [ADDR_W-1:0] i_addr_in,
  input  logic [DATA_W-1:0] i_wdata_in,
  input  logic              i_we_in,
  output logic              o_gnt_in,
  output logic              o_rvalid_in,
  input  logic              i_req_disp,
  input  logic [ADDR_W-1:0] i_addr_disp,
  output logic              o_gnt_disp,
  output logic              o_rvalid_disp,
  input  logic              i_req_calc,
  input  logic [ADDR_W-1:0] i_addr_calc,
  input  logic [DATA_W-1:0] i_wdata_calc,
  input  logic              i_we_calc,
  output logic              o_gnt_calc,
  output logic              o_rvalid_calc,
  output logic [ADDR_W-1:0] o_storage_addr,
  output logic [DATA_W-1:0] o_storage_data,
  output logic              o_storage_we,
  input  logic [DATA_W-1:0] i_storage_rdata,
  output logic [DATA_W-1:0] o_rdata,
  output arb_state_t        dbg_state
);

  // Burst counter holds 0 .. MAX_BURST-1.
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  arb_state_t         state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] req_vec, win, others;
  logic               beat;

  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               we_q;

  // Read return pipeline: stage 1 tracks the cycle the address is on the
  // storage, stage 2 is the cycle the data comes back. The tag is the owner
  // at acceptance, so data is delivered even after the grant has dropped.
  logic               rd_vld_q;
  logic [1:0]         rd_tag_q;
  logic [NUM_REQ-1:0] rvalid_q;

  assign req_vec = {i_req_calc, i_req_disp, i_req_in};
  assign others  = req_vec & ~req_onehot(owner_q);

  storage_arbiter_rr_pick3 u_pick (
    .req    (req_vec),
    .ptr    (ptr_q),
    .winner (win)
  );

  // Payload of the current owner. Display is read-only, so its write
  // enable and data are forced to zero.
  always_comb begin
    sel_addr  = i_addr_in;
    sel_wdata = i_wdata_in;
    sel_we    = i_we_in;
    case (owner_q)
      REQ_DISP: begin
        sel_addr  = i_addr_disp;
        sel_wdata = '0;
        sel_we    = 1'b0;
      end
      REQ_CALC: begin
        sel_addr  = i_addr_calc;
        sel_wdata = i_wdata_calc;
        sel_we    = i_we_calc;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    beat    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          state_d = ST_GRANT;
          owner_d = onehot_idx(win);
          gnt_d   = win;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (!req_vec[owner_q]) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          ptr_d   = next_req(owner_q);
          cnt_d   = '0;
        end else begin
          beat = 1'b1;
          if (cnt_q == CNT_LAST) begin
            // Burst limit only forces a release when someone is waiting;
            // otherwise the count restarts and the owner keeps going.
            cnt_d = '0;
            if (|others) begin
              state_d = ST_IDLE;
              gnt_d   = '0;
              ptr_d   = next_req(owner_q);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_IN;
      ptr_q   <= REQ_IN;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_tag_q <= REQ_IN;
      rvalid_q <= '0;
    end else begin
      if (beat) begin
        addr_q <= sel_addr;
        data_q <= sel_wdata;
        we_q   <= sel_we;
      end else begin
        we_q   <= 1'b0;
      end
      rd_vld_q <= beat & ~sel_we;
      rd_tag_q <= owner_q;
      rvalid_q <= rd_vld_q ? req_onehot(rd_tag_q) : '0;
    end
  end

  assign o_gnt_in       = gnt_q[REQ_IN];
  assign o_gnt_disp     = gnt_q[REQ_DISP];
  assign o_gnt_calc     = gnt_q[REQ_CALC];
  assign o_rvalid_in    = rvalid_q[REQ_IN];
  assign o_rvalid_disp  = rvalid_q[REQ_DISP];
  assign o_rvalid_calc  = rvalid_q[REQ_CALC];
  assign o_storage_addr = addr_q;
  assign o_storage_data = data_q;
  assign o_storage_we   = we_q;
  assign o_rdata        = i_storage_rdata;
  assign dbg_state      = state_q;

endmodule
